// File: rtl/instr_asm_pkg.sv
// instr_asm_pkg
//   Shared types and defaults for the instruction assembler.
//   - state_t   : assembler FSM states
//   - is_long() : opcode-length lookup against a long-opcode mask
//   - DEF_*     : default widths used by instr_assembler
package instr_asm_pkg;

    localparam int          DEF_DATA_W     = 8;
    localparam int          DEF_OPC_W      = 3;
    localparam int          DEF_OPND_BYTES = 1;
    localparam logic [7:0]  DEF_LONG_MASK  = 8'hF0;

    // Widest opcode the lookup helper supports; callers zero-extend into it.
    localparam int MAX_OPC_W = 8;
    localparam int MASK_W    = 2 ** MAX_OPC_W;

    typedef enum logic [1:0] {
        S_OPC  = 2'd0,
        S_OPND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Bit k of mask set means opcode k carries operand bytes.
    function automatic logic is_long(input logic [MAX_OPC_W-1:0] opcode,
                                     input logic [MASK_W-1:0]    mask);
        return mask[opcode];
    endfunction

endpackage

// File: rtl/instr_operand_shifter.sv
// instr_operand_shifter
//   Operand register for the assembler. Each write lands the incoming byte
//   in lane idx (lane 0 = bits [DATA_W-1:0], little-endian). clr zeroes all
//   lanes and wins over wr_en.
// Ports:
//   clk, rst     clock, async active-low reset
//   clr          zero the whole operand
//   wr_en        write din into lane idx
//   idx          lane index (operand byte count)
//   din          byte to write
//   ad2          assembled operand
module instr_operand_shifter #(
    parameter int DATA_W     = 8,
    parameter int OPND_BYTES = 1,
    parameter int CNT_W      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [CNT_W-1:0]             idx,
    input  logic [DATA_W-1:0]            din,
    output logic [OPND_BYTES*DATA_W-1:0] ad2
);

    logic [OPND_BYTES-1:0][DATA_W-1:0] lanes;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lanes <= '0;
        end else if (clr) begin
            lanes <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < OPND_BYTES; i++) begin
                if (idx == CNT_W'(i)) lanes[i] <= din;
            end
        end
    end

    assign ad2 = lanes;

endmodule

// File: rtl/instr_assembler.sv
// instr_assembler
//   Assembles variable-length instructions (opcode byte + 0 or OPND_BYTES
//   operand bytes) from a byte-serial valid/ready fetch stream and presents
//   them on a valid/ready output to decode.
//   Build option: INSTR_ASM_PREFETCH_EN -- accept the next opcode byte in the
//   same cycle as the output handoff (1 short instruction per cycle).
// Ports:
//   clk, rst               clock, async active-low reset
//   flush                  drop partial/held instruction (highest priority)
//   in_valid/in_ready/in_data    fetch byte stream
//   out_valid/out_ready          assembled instruction handshake
//   ins                    opcode (top OPC_W bits of opcode byte)
//   ad1                    register address (low bits of opcode byte)
//   ad2                    operand, little-endian
module instr_assembler
    import instr_asm_pkg::*;
#(
    parameter int                  DATA_W     = DEF_DATA_W,
    parameter int                  OPC_W      = DEF_OPC_W,
    parameter int                  OPND_BYTES = DEF_OPND_BYTES,
    parameter logic [2**OPC_W-1:0] LONG_MASK  = DEF_LONG_MASK
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OPC_W-1:0]             ins,
    output logic [DATA_W-OPC_W-1:0]      ad1,
    output logic [OPND_BYTES*DATA_W-1:0] ad2
);

    localparam int CNT_W = $clog2(OPND_BYTES + 1);
    localparam int AD1_W = DATA_W - OPC_W;

`ifdef INSTR_ASM_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [OPC_W-1:0] opc;
    logic             opc_long;
    logic             acc;
    logic             opc_take;
    logic             opnd_take;
    logic             last_slot;

    assign opc      = in_data[DATA_W-1 -: OPC_W];
    assign opc_long = is_long(MAX_OPC_W'(opc), MASK_W'(LONG_MASK));

    always_comb begin
        in_ready = 1'b1;
        if (state == S_HOLD) in_ready = PREFETCH ? out_ready : 1'b0;
    end

    // flush masks the transfer even though in_ready stays driven.
    assign acc       = in_valid & in_ready & ~flush;
    // In S_HOLD in_ready can only be high with prefetch, and then only
    // alongside out_ready, so an accept there is always the next opcode.
    assign opc_take  = acc & ((state == S_OPC) | (state == S_HOLD));
    assign opnd_take = acc & (state == S_OPND);
    assign last_slot = (cnt == CNT_W'(OPND_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_OPC;
            cnt       <= '0;
            out_valid <= 1'b0;
            ins       <= '0;
            ad1       <= '0;
        end else if (flush) begin
            state     <= S_OPC;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (opc_take) begin
            ins <= opc;
            ad1 <= in_data[AD1_W-1:0];
            cnt <= '0;
            if (opc_long) begin
                state     <= S_OPND;
                out_valid <= 1'b0;
            end else begin
                state     <= S_HOLD;
                out_valid <= 1'b1;
            end
        end else begin
            case (state)
                S_OPND: if (opnd_take) begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_slot) begin
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                    end
                end
                S_HOLD: if (out_ready) begin
                    state     <= S_OPC;
                    out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    instr_operand_shifter #(
        .DATA_W     (DATA_W),
        .OPND_BYTES (OPND_BYTES),
        .CNT_W      (CNT_W)
    ) u_opnd (
        .clk   (clk),
        .rst   (rst),
        .clr   (opc_take),
        .wr_en (opnd_take),
        .idx   (cnt),
        .din   (in_data),
        .ad2   (ad2)
    );

endmodule

// File: tb/tb_instr_assembler.sv
// tb_instr_assembler
//   Randomized + directed stimulus; expected instructions are pushed into a
//   scoreboard queue when their last byte is accepted, and a monitor pops and
//   compares on every output handoff. Built with OPND_BYTES=2.
module tb_instr_assembler;

    localparam int         DATA_W     = 8;
    localparam int         OPC_W      = 3;
    localparam int         OPND_BYTES = 2;
    localparam logic [7:0] LONG_MASK  = 8'hF0;
    localparam int         AD1_W      = DATA_W - OPC_W;

`ifdef INSTR_ASM_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    logic                         clk, rst, flush, in_valid, in_ready;
    logic [DATA_W-1:0]            in_data;
    logic                         out_valid, out_ready;
    logic [OPC_W-1:0]             ins;
    logic [AD1_W-1:0]             ad1;
    logic [OPND_BYTES*DATA_W-1:0] ad2;

    instr_assembler #(
        .DATA_W(DATA_W), .OPC_W(OPC_W), .OPND_BYTES(OPND_BYTES), .LONG_MASK(LONG_MASK)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .ins(ins), .ad1(ad1), .ad2(ad2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int ins; int ad1; longint ad2; } exp_t;
    exp_t sb[$];

    int total  = 0;
    int passed = 0;
    int ordy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit mon_en = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Decode-side ready, changed on the falling edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ordy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples 1 time unit before each rising edge.
    initial begin : monitor
        bit  hold_prev = 0, flush_prev = 0;
        int  p_ins = 0, p_ad1 = 0;
        longint p_ad2 = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst || !mon_en) begin
                hold_prev = 0;
            end else begin
                chk("in_ready_rule", in_ready,
                    out_valid ? (PREFETCH ? out_ready : 1'b0) : 1'b1);
                if (hold_prev && !flush_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_ins", ins, p_ins);
                    chk("hold_ad1", ad1, p_ad1);
                    chk("hold_ad2", ad2, p_ad2);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("ins", ins, e.ins);
                        chk("ad1", ad1, e.ad1);
                        chk("ad2", ad2, e.ad2);
                    end
                end
                hold_prev  = out_valid && !out_ready;
                flush_prev = flush;
                p_ins = ins; p_ad1 = ad1; p_ad2 = ad2;
            end
        end
    end

    // Present a byte from a falling edge until accepted; returns on the
    // falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!done) begin
            #4;
            done = in_ready;
            @(negedge clk);
            n++;
            if (!done && n > 300) begin
                chk("accept_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
    endtask

    task automatic flush_cycle(input bit with_byte, input logic [7:0] b);
        flush    = 1'b1;
        in_valid = with_byte;
        in_data  = b;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Reference: opcode = top OPC_W bits, address = the rest, long when the
    // opcode's bit is set in LONG_MASK, operand bytes little-endian.
    task automatic send_instr(input logic [7:0] b, input logic [31:0] opval,
                              input int max_gap, input bit abort);
        exp_t e;
        int   lng;
        e.ins = int'(b) >> AD1_W;
        e.ad1 = int'(b) % (1 << AD1_W);
        e.ad2 = 0;
        lng   = (int'(LONG_MASK) >> e.ins) & 1;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        send_byte(b);
        if (lng == 0) begin
            sb.push_back(e);
        end else if (abort) begin
            flush_cycle($urandom_range(0, 1), 8'($urandom_range(0, 255)));
        end else begin
            for (int k = 0; k < OPND_BYTES; k++) begin
                logic [7:0] ob;
                ob = 8'(opval >> (8 * k));
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
                send_byte(ob);
                e.ad2 += longint'(ob) << (8 * k);
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(nm, sb.size(), 0);
    endtask

    initial begin : stim
        int cyc, acc_n;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_ins", ins, 0);
        chk("rst_ad1", ad1, 0);
        chk("rst_ad2", ad2, 0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        mon_en = 1;

        // Short instruction: out_valid the cycle after the byte, then handoff.
        send_instr(8'h25, 0, 0, 0);
        #4 chk("short_latency", out_valid, 1);
        @(negedge clk);
        #4 chk("short_done", out_valid, 0);
        @(negedge clk);

        // Long instructions.
        send_instr(8'h9F, 32'h003C, 0, 0);
        send_instr(8'hE1, 32'h1234, 0, 0);
        wait_drain("long_drain");

        // Backpressure: held for several cycles, single handoff.
        ordy_mode = 2;
        send_instr(8'h25, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("bp_held", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        ordy_mode = 1;
        wait_drain("bp_drain");
        chk("bp_after", out_valid, 0);

        // Flush before the operand: nothing is produced.
        send_byte(8'h9F);
        flush_cycle(1, 8'h3C);
        repeat (2) begin
            #4 chk("flush_no_out", out_valid, 0);
            @(negedge clk);
        end
        // Flush drops a byte presented in S_OPC.
        flush_cycle(1, 8'h25);
        #4 chk("flush_drop_byte", out_valid, 0);
        @(negedge clk);
        send_instr(8'h25, 0, 0, 0);
        wait_drain("flush_drain");

        // Async reset mid-operand discards the partial instruction.
        send_byte(8'h9F);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ins", ins, 0);
        chk("arst_ad1", ad1, 0);
        chk("arst_ad2", ad2, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_instr(8'h26, 0, 0, 0);
        wait_drain("arst_drain");

        // Throughput: three short opcodes streamed with out_ready held high.
        cyc = 0; acc_n = 0;
        in_valid = 1'b1;
        in_data  = 8'h25;
        while (acc_n < 3 && cyc < 20) begin
            #4;
            if (in_ready) begin
                exp_t e;
                e.ins = 1; e.ad1 = 5 + acc_n; e.ad2 = 0;
                sb.push_back(e);
                acc_n++;
            end
            cyc++;
            @(negedge clk);
            in_data = 8'(8'h25 + acc_n);
        end
        in_valid = 1'b0;
        chk("stream_cycles", cyc, PREFETCH ? 3 : 5);
        wait_drain("stream_drain");

        // Randomized phase: random opcodes/operands, gaps, readiness, and
        // occasional flushes after a long opcode.
        ordy_mode = 0;
        for (int i = 0; i < 200; i++) begin
            send_instr(8'($urandom_range(0, 255)), $urandom, 2,
                       ($urandom_range(0, 9) == 0));
        end
        ordy_mode = 1;
        wait_drain("rand_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
